// File: rtl/smalldemux_if.sv
// Bundle for the smalldemux serial-in / 4-lane-out path.
// The master side feeds values and consumes frames. The slave side is the demux.
interface smalldemux_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             auto_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] zero;
   logic [WIDTH-1:0] one;
   logic [WIDTH-1:0] two;
   logic [WIDTH-1:0] three;
   logic [3:0]       fill_mask;
   logic             out_valid;
   logic             out_ready;
   logic             ovw_err;

   modport master (
      output in_data, in_sel, auto_sel, in_valid, out_ready,
      input  in_ready, zero, one, two, three, fill_mask, out_valid, ovw_err
   );

   modport slave (
      input  in_data, in_sel, auto_sel, in_valid, out_ready,
      output in_ready, zero, one, two, three, fill_mask, out_valid, ovw_err
   );
endinterface

// File: rtl/smalldemux.sv
// smalldemux: steers a stream of WIDTH-bit values into four lane registers.
// A lane comes either from in_sel or from an internal round-robin pointer.
// Once all four lanes are written, the frame is presented with a valid/ready handshake.
// A drain and a new accept may happen in the same cycle, so a full frame costs no bubble.
module smalldemux #(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   smalldemux_if.slave  bus
);
   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t           r_state;
   logic [1:0]       r_ptr;
   logic [WIDTH-1:0] r_lane [4];
   logic [3:0]       r_mask;
   logic             r_out_valid;
   logic             r_ovw;

   logic             w_drain;
   logic             w_ready;
   logic             w_accept;
   logic [1:0]       w_lane;
   logic [3:0]       w_onehot;
   logic [3:0]       w_mask_next;

   // Decode the handshake and the destination lane from the current state
   always_comb begin
      w_drain  = (r_state == FULL) & bus.out_ready;
      w_ready  = (r_state == FILL) | w_drain;
      w_accept = bus.in_valid & w_ready;
      // A drain restarts the auto pointer, so a same-cycle auto write lands in lane 0
      if (bus.auto_sel)
         w_lane = w_drain ? 2'd0 : r_ptr;
      else
         w_lane = bus.in_sel;
      w_onehot    = 4'b0001 << w_lane;
      w_mask_next = r_mask | w_onehot;
   end

   // Frame assembly state machine with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_ptr       <= 2'd0;
         r_mask      <= 4'b0000;
         r_out_valid <= 1'b0;
         r_ovw       <= 1'b0;
         for (int i = 0; i < 4; i++) r_lane[i] <= '0;
      end else begin
         r_ovw <= 1'b0;
         if (w_drain) begin
            // Frame handed off. An optional new write starts the next frame.
            r_state     <= FILL;
            r_out_valid <= 1'b0;
            r_mask      <= w_accept ? w_onehot : 4'b0000;
            r_ptr       <= (w_accept & bus.auto_sel) ? 2'd1 : 2'd0;
            if (w_accept) r_lane[w_lane] <= bus.in_data;
         end else if (w_accept) begin
            r_lane[w_lane] <= bus.in_data;
            if (bus.auto_sel) r_ptr <= r_ptr + 2'd1;
            if ((r_mask & w_onehot) != 4'b0000) begin
               // Repeat write to a lane: last write wins, and the mask is left untouched
               r_ovw <= 1'b1;
            end else begin
               r_mask <= w_mask_next;
               if (w_mask_next == 4'b1111) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.zero      = r_lane[0];
   assign bus.one       = r_lane[1];
   assign bus.two       = r_lane[2];
   assign bus.three     = r_lane[3];
   assign bus.fill_mask = r_mask;
   assign bus.out_valid = r_out_valid;
   assign bus.ovw_err   = r_ovw;
endmodule

// File: tb/tb_smalldemux.sv
// Testbench for smalldemux.
// The driver keeps a set-based reference model and pushes each completed frame onto a queue.
// A monitor pops a frame and compares it whenever the DUT hands a frame off.
module tb_smalldemux;
   logic clk;
   logic rst_n;

   smalldemux_if #(.WIDTH(4)) bus ();

   smalldemux #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: lane contents, set of lanes written, frame-complete flag
   logic [3:0]  m_lane [4];
   logic [3:0]  m_mask;
   bit          m_full;
   int          m_ptr;
   int          m_acc;
   bit          m_ovw;
   logic [15:0] exp_q [$];
   logic [15:0] mon_f;

   function automatic void chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m_lane[i] = 4'h0;
      m_mask = 4'h0;
      m_full = 1'b0;
      m_ptr  = 0;
      m_ovw  = 1'b0;
      exp_q.delete();
   endfunction

   // Monitor: a frame leaves when out_valid and out_ready are both high
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_unexpected: got %0h, expected no frame", {bus.three, bus.two, bus.one, bus.zero});
         end else begin
            mon_f = exp_q.pop_front();
            chk("frame", int'({bus.three, bus.two, bus.one, bus.zero}), int'(mon_f));
         end
      end
   end

   // One clock of stimulus. It is entered and left at posedge+1.
   task automatic step(input bit v, input logic [1:0] s, input bit a, input logic [3:0] d, input bit ordy);
      int L;
      bit acc;
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.auto_sel  = a;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
      chk("in_ready", int'(bus.in_ready), int'(!m_full || ordy));
      acc = v && (!m_full || ordy);
      @(posedge clk);
      #1;
      m_ovw = 1'b0;
      if (m_full && ordy) begin
         m_full = 1'b0;
         m_mask = 4'h0;
         m_ptr  = 0;
      end
      if (acc) begin
         L = a ? m_ptr : int'(s);
         m_acc++;
         if (m_mask[L]) m_ovw = 1'b1;
         m_lane[L] = d;
         m_mask[L] = 1'b1;
         if (a) m_ptr = (m_ptr + 1) % 4;
         if (m_mask == 4'hF) begin
            m_full = 1'b1;
            exp_q.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
         end
      end
      chk("fill_mask", int'(bus.fill_mask), int'(m_mask));
      chk("out_valid", int'(bus.out_valid), int'(m_full));
      chk("ovw_err", int'(bus.ovw_err), int'(m_ovw));
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      chk("rst_zero", int'(bus.zero), 0);
      chk("rst_one", int'(bus.one), 0);
      chk("rst_two", int'(bus.two), 0);
      chk("rst_three", int'(bus.three), 0);
      chk("rst_mask", int'(bus.fill_mask), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_ovw", int'(bus.ovw_err), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int base;
      rst_n         = 1'b0;
      bus.in_data   = 4'h0;
      bus.in_sel    = 2'd0;
      bus.auto_sel  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      m_acc         = 0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // auto mode, back-to-back with out_ready high
      step(1, 2'd0, 1, 4'h3, 1);
      step(1, 2'd0, 1, 4'hA, 1);
      step(1, 2'd0, 1, 4'h5, 1);
      step(1, 2'd0, 1, 4'hC, 1);
      chk("t1_valid", int'(bus.out_valid), 1);
      chk("t1_zero", int'(bus.zero), 'h3);
      chk("t1_one", int'(bus.one), 'hA);
      chk("t1_two", int'(bus.two), 'h5);
      chk("t1_three", int'(bus.three), 'hC);
      step(0, 2'd0, 1, 4'h0, 1);
      chk("t1_mask_after", int'(bus.fill_mask), 0);
      chk("t1_valid_after", int'(bus.out_valid), 0);

      // manual mode, scattered lane order
      step(1, 2'd3, 0, 4'h1, 0);
      chk("t2_mask1", int'(bus.fill_mask), 'b1000);
      step(1, 2'd0, 0, 4'h2, 0);
      chk("t2_mask2", int'(bus.fill_mask), 'b1001);
      step(1, 2'd2, 0, 4'h3, 0);
      chk("t2_mask3", int'(bus.fill_mask), 'b1101);
      step(1, 2'd1, 0, 4'h4, 0);
      chk("t2_mask4", int'(bus.fill_mask), 'b1111);
      chk("t2_lanes", int'({bus.three, bus.two, bus.one, bus.zero}), 'h1342);
      step(0, 2'd0, 0, 4'h0, 1);

      // overwrite of lane 1
      step(1, 2'd1, 0, 4'h7, 0);
      step(1, 2'd1, 0, 4'h9, 0);
      chk("t3_ovw", int'(bus.ovw_err), 1);
      chk("t3_one", int'(bus.one), 'h9);
      step(1, 2'd0, 0, 4'h1, 0);
      chk("t3_ovw_once", int'(bus.ovw_err), 0);
      step(1, 2'd2, 0, 4'h2, 0);
      chk("t3_not_yet", int'(bus.out_valid), 0);
      step(1, 2'd3, 0, 4'h3, 0);
      chk("t3_valid", int'(bus.out_valid), 1);
      step(0, 2'd0, 0, 4'h0, 1);

      // back-pressure, then a drain and an accept in the same cycle
      step(1, 2'd0, 1, 4'h1, 0);
      step(1, 2'd0, 1, 4'h2, 0);
      step(1, 2'd0, 1, 4'h3, 0);
      step(1, 2'd0, 1, 4'h4, 0);
      for (int i = 0; i < 5; i++) step(1, 2'd0, 1, 4'hB, 0);
      chk("t4_held", int'({bus.three, bus.two, bus.one, bus.zero}), 'h4321);
      chk("t4_valid_held", int'(bus.out_valid), 1);
      step(1, 2'd0, 1, 4'hE, 1);
      chk("t4_mask", int'(bus.fill_mask), 'b0001);
      chk("t4_zero", int'(bus.zero), 'hE);
      step(1, 2'd0, 1, 4'h6, 1);
      chk("t4_ptr1", int'(bus.one), 'h6);
      step(1, 2'd0, 1, 4'h7, 1);
      step(1, 2'd0, 1, 4'h8, 1);
      step(0, 2'd0, 1, 4'h0, 1);

      // reset in the middle of a frame
      step(1, 2'd0, 0, 4'hF, 0);
      step(1, 2'd1, 0, 4'hF, 0);
      do_reset();
      step(1, 2'd2, 0, 4'h5, 0);
      step(1, 2'd3, 0, 4'h6, 0);
      step(1, 2'd0, 0, 4'h7, 0);
      chk("t5_not_yet", int'(bus.out_valid), 0);
      step(1, 2'd1, 0, 4'h8, 0);
      chk("t5_lanes", int'({bus.three, bus.two, bus.one, bus.zero}), 'h6587);
      step(0, 2'd0, 0, 4'h0, 1);

      // random manual stream
      base = m_acc;
      cyc  = 0;
      while (m_acc < base + 200 && cyc < 5000) begin
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 0,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         cyc++;
      end
      chk("rand_accepts", m_acc - base, 200);
      for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 4'h0, 1);
      chk("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/smalldemux.md
Name: smalldemux

Overview:
- Inverse of the 4:1 nibble selector. Accepts a stream of WIDTH-bit values, each steered to one of four lane registers (zero/one/two/three) by a 2-bit select or by an internal round-robin pointer.
- Presents the assembled 4-lane frame with a valid/ready handshake once every lane has been written.
- Feeds the parallel compare stage of proto_sort from a serial nibble source.

Parameters:
- WIDTH, 4, bit width of each value and each lane register.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset; synchronous, active-low.
- in_data, input, WIDTH, value to store.
- in_sel, input, 2, destination lane (00=zero, 01=one, 10=two, 11=three). Used only when auto_sel=0.
- auto_sel, input, 1:
  - 1: lane comes from the internal pointer.
  - 0: lane comes from in_sel.
  - Must be held stable within a frame.
- in_valid, input, 1, in_data/in_sel are valid.
- in_ready, output, 1, block accepts the input this cycle.
- zero, output, WIDTH, lane 0 register.
- one, output, WIDTH, lane 1 register.
- two, output, WIDTH, lane 2 register.
- three, output, WIDTH, lane 3 register.
- fill_mask, output, 4, bit i set = lane i written in the current frame.
- out_valid, output, 1, all four lanes written; frame presented.
- out_ready, input, 1, consumer accepts the frame.
- ovw_err, output, 1, one-cycle pulse when an accepted write targets a lane already set in fill_mask.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - zero/one/two/three = 0, fill_mask = 0, pointer = 0, out_valid = 0, ovw_err = 0, state = FILL.
  - Reset mid-frame discards the partial frame.
  - Reset while in FULL discards the frame; out_valid is 0 on the next cycle.
- Accept condition: in_valid & in_ready. Lane index L = auto_sel ? pointer : in_sel.
- in_ready = (state==FILL) | (state==FULL & out_ready). This is combinational from state and out_ready.
- State FILL:
  - On accept: lane L <= in_data and fill_mask[L] <= 1.
  - If auto_sel, pointer <= pointer+1, wrapping 3->0.
  - If fill_mask becomes 4'b1111, go to FULL and assert out_valid on the next cycle. Latency is 1 cycle from the 4th distinct-lane accept to out_valid=1.
  - Minimum frame is 4 accepts.
- Overwrite (manual mode only; auto mode cannot repeat a lane within a frame):
  - Accept to a lane already set in fill_mask overwrites the lane register (last write wins).
  - fill_mask is unchanged and ovw_err pulses high for 1 cycle.
- State FULL:
  - out_valid = 1.
  - Lane registers and fill_mask are held stable while out_ready=0.
  - in_ready = 0 while out_ready=0.
- Drain (FULL & out_ready=1, no accept): fill_mask <= 0, pointer <= 0, state <= FILL, out_valid <= 0.
  - Lane registers retain their old values; they are don't-care until the next frame completes.
- Simultaneous drain and accept in the same cycle:
  - Frame handed off.
  - fill_mask <= one-hot(L); lane L <= in_data.
  - pointer <= 1 in auto mode, since L = 0 after the drain.
  - state <= FILL.
- Outputs zero/one/two/three are direct register outputs; there is no combinational path from in_data.
- in_valid without in_ready: nothing changes. The source must hold its data.
- out_valid=1 with out_ready=0 persists indefinitely.

Test Plan:
- Reset, then auto_sel=1, out_ready=1, feed 4'h3, 4'hA, 4'h5, 4'hC back-to-back -> the cycle after the 4th accept, out_valid=1 with zero=3, one=A, two=5, three=C. The next cycle fill_mask=0 and out_valid=0.
- Manual mode, in_sel order 11, 00, 10, 01 with data 1, 2, 3, 4 -> zero=2, one=4, two=3, three=1, out_valid=1. The fill_mask sequence is 1000, 1001, 1101, 1111.
- Manual mode, write lane 01 twice (7, then 9), then lanes 00/10/11 -> ovw_err pulses once on the second write, one=9, out_valid only after all four lanes are written.
- Complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, lanes held, out_valid held. Raise out_ready with in_valid=1, data E, auto mode -> frame drained, fill_mask=0001, zero=E, pointer=1.
- Assert rst_n=0 for one cycle after 2 accepts, then feed 4 values -> out_valid appears only after 4 new accepts, and the old values are not merged into the new frame.
- Random manual stream of 200 accepts with random out_ready -> a scoreboard matches every presented frame (last write per lane) and no frame is lost or duplicated.
